clock_generator: RTL and testbench
==================================

CLOCK_GENERATOR -- requirements
Module: clock_generator

Interface
- REQ-001 Parameter: DIV_W, default 8, width of the half-period control and the internal divide counter.
- REQ-002 Parameter: CNT_W, default 32, width of the generated-cycle counter.
- REQ-003 Parameter: RESET_HALF, default 5, half-period in clk cycles that applies from reset until the first reload.
- REQ-004 Port: clk, input, 1 bit, reference clock; all logic is clocked on its rising edge.
- REQ-005 Port: rst_n, input, 1 bit, asynchronous active-low reset.
- REQ-006 Port: en, input, 1 bit, run enable for the generated clock.
- REQ-007 Port: half_period, input, DIV_W bits, number of clk cycles per generated-clock phase.
- REQ-008 Port: clock, output, 1 bit, generated clock, driven from a register.
- REQ-009 Port: clock_rise, output, 1 bit, one-clk pulse in the cycle when clock goes 0->1.
- REQ-010 Port: clock_fall, output, 1 bit, one-clk pulse in the cycle when clock goes 1->0.
- REQ-011 Port: cycle_count, output, CNT_W bits, count of generated rising edges.
- REQ-012 clock SHALL be the first port in the declaration, so a single positional connection binds it; clk, rst_n, en and half_period follow in that order.

Function
- REQ-013 An internal counter SHALL increment on every clk edge while the block is running; when it reaches eff_half-1 it SHALL return to 0 and clock SHALL toggle.
- REQ-014 eff_half is a shadow register that SHALL reload from half_period only on a toggle edge; a value of 0 SHALL load as 1. The shadow prevents runt or glitch pulses.
- REQ-015 For a steady value N, the clock period SHALL be 2N clk cycles with a 50 % duty cycle. N=1 gives a clock at half the clk frequency.
- REQ-016 clock_rise and clock_fall SHALL be registered and asserted in the same cycle that the clock register takes its new value; they are never both high.
- REQ-017 cycle_count SHALL increment by 1 on each clock_rise and wrap from 2^CNT_W-1 to 0.
- REQ-018 en low while clock is high: clock SHALL finish its current high phase, fall normally, then hold at 0.
- REQ-019 en low while clock is low: clock SHALL hold at 0 and the counter SHALL be held at 0.
- REQ-020 When en rises, the first rising edge SHALL occur eff_half clk cycles later.
- REQ-021 A change of half_period in the same cycle as a toggle SHALL take effect for the phase that starts at that toggle.
- REQ-022 No output SHALL have a combinational path from any input.

Reset
- REQ-023 While rst_n is low, immediately and independently of clk: clock=0, clock_rise=0, clock_fall=0, cycle_count=0, counter=0, eff_half=RESET_HALF.
- REQ-024 After rst_n is released, operation SHALL start on the first clk edge at which rst_n is high.
- REQ-025 Reset asserted mid-phase SHALL abort the phase with no pulse emitted.

Configuration
- REQ-026 Macro CLOCK_GENERATOR_CYCLE_COUNT_EN defined: cycle_count SHALL behave as in REQ-017.
- REQ-027 Macro CLOCK_GENERATOR_CYCLE_COUNT_EN undefined: the counter SHALL be omitted, cycle_count SHALL be tied to 0, and the port list SHALL be unchanged.

Structure
- REQ-028 A shared package clock_generator_pkg SHALL hold the default constants for DIV_W, CNT_W and RESET_HALF, plus a typedef for the half-period type.
- REQ-029 The divide counter and shadow-reload logic SHALL form one sub-module, clkgen_divider. The top level adds the enable/stop-low control, the edge pulses and cycle_count.

Verification
- REQ-030 Release reset with en=1 and half_period=5: first clock rise at the 5th clk edge, then period 10, clock_rise pulses 10 cycles apart, cycle_count 1,2,3.
- REQ-031 half_period=0 with en=1: clock toggles every clk cycle (period 2), matching half_period=1.
- REQ-032 Change half_period from 5 to 3 in mid-phase: the current phase completes at 5, and the next phase lasts 3 with no runt pulse.
- REQ-033 Drop en 2 cycles into a high phase with N=5: clock stays high 3 more cycles, falls with clock_fall=1, then stays 0; raise en: rise 5 cycles later.
- REQ-034 Assert rst_n low mid-high-phase: clock, clock_rise, clock_fall and cycle_count go to 0 before the next clk edge; restart as in REQ-030.
- REQ-035 CNT_W=4 with the macro defined: after 16 rises, cycle_count wraps to 0. Build without the macro: cycle_count stays 0 throughout.

Source files
------------

// File: rtl/clock_generator_pkg.sv
// Shared constants and types for the clock generator.
package clock_generator_pkg;

   localparam int DIV_W_DEF      = 8;
   localparam int CNT_W_DEF      = 32;
   localparam int RESET_HALF_DEF = 5;

   // Half-period control word at the default divider width.
   typedef logic [DIV_W_DEF-1:0] half_t;

endpackage

// File: rtl/clkgen_divider.sv
// Phase divider for the generated clock.
// It counts clk edges within a phase and raises tick on the last edge of each phase.
// The half-period is copied into a shadow register only on a tick.
// Because of that, a half_period change mid-phase never shortens or stretches the phase in flight.
module clkgen_divider
   import clock_generator_pkg::*;
#(
   parameter int DIV_W      = DIV_W_DEF,
   parameter int RESET_HALF = RESET_HALF_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic [DIV_W-1:0] half_period,
   output logic             tick
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] eff_half;
   logic [DIV_W-1:0] load_val;

   // A zero request is treated as the fastest legal setting.
   assign load_val = (half_period == '0) ? DIV_W'(1) : half_period;

   // Last clk edge of the current phase.
   assign tick = run && (cnt == (eff_half - DIV_W'(1)));

   // Phase counter plus shadow half-period; while stopped, the counter is parked at 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         eff_half <= DIV_W'(RESET_HALF);
      end else if (!run) begin
         cnt      <= '0;
      end else if (tick) begin
         cnt      <= '0;
         eff_half <= load_val;
      end else begin
         cnt      <= cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/clock_generator.sv
// Registered clock generator with a programmable half-period and edge pulses.
// Define CLOCK_GENERATOR_CYCLE_COUNT_EN to build the rising-edge counter.
// Without that define, cycle_count is tied to 0 and the port list stays the same.
module clock_generator
   import clock_generator_pkg::*;
#(
   parameter int DIV_W      = DIV_W_DEF,
   parameter int CNT_W      = CNT_W_DEF,
   parameter int RESET_HALF = RESET_HALF_DEF
) (
   output logic             clock,
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [DIV_W-1:0] half_period,
   output logic             clock_rise,
   output logic             clock_fall,
   output logic [CNT_W-1:0] cycle_count
);

   logic run;
   logic tick;

   // A high phase always runs to completion, so the clock can only stop while it is low.
   assign run = en | clock;

   clkgen_divider #(
      .DIV_W      (DIV_W),
      .RESET_HALF (RESET_HALF)
   ) u_div (
      .clk         (clk),
      .rst_n       (rst_n),
      .run         (run),
      .half_period (half_period),
      .tick        (tick)
   );

   // Clock register and edge pulses change on the same edge, so the pulses line up with the new level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clock      <= 1'b0;
         clock_rise <= 1'b0;
         clock_fall <= 1'b0;
      end else begin
         clock      <= clock ^ tick;
         clock_rise <= tick & ~clock;
         clock_fall <= tick & clock;
      end
   end

`ifdef CLOCK_GENERATOR_CYCLE_COUNT_EN
   logic [CNT_W-1:0] cyc_q;

   // Count generated rising edges; the counter wraps naturally at full scale.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_q <= '0;
      end else if (tick && !clock) begin
         cyc_q <= cyc_q + CNT_W'(1);
      end
   end

   assign cycle_count = cyc_q;
`else
   assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_clock_generator.sv
// Self-checking bench for clock_generator.
// It combines directed scenarios with a randomized stretch.
// All of it is checked against a phase-length reference model.
module tb_clock_generator;

   localparam int DW = 8;
   localparam int CW = 4;
   localparam int RH = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic [DW-1:0] half_period;
   logic          clock;
   logic          clock_rise;
   logic          clock_fall;
   logic [CW-1:0] cycle_count;

   int checks   = 0;
   int failures = 0;

   // Reference model state: output level, edges spent in the current phase,
   // length of the current phase, and the number of rises modulo 2^CW.
   int m_clk, m_el, m_len, m_cnt, m_rise, m_fall;
   logic          cur_en;
   logic [DW-1:0] cur_hp;

   clock_generator #(.DIV_W(DW), .CNT_W(CW), .RESET_HALF(RH)) dut (
      .clock       (clock),
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .half_period (half_period),
      .clock_rise  (clock_rise),
      .clock_fall  (clock_fall),
      .cycle_count (cycle_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_clk = 0; m_el = 0; m_len = RH; m_cnt = 0; m_rise = 0; m_fall = 0;
   endtask

   // One reference clk edge: a phase lasts m_len edges.
   // While the output is low and en is low, nothing advances.
   task automatic model_edge(input logic e, input logic [DW-1:0] hp);
      m_rise = 0; m_fall = 0;
      if (!e && m_clk == 0) begin
         m_el = 0;
      end else begin
         m_el++;
         if (m_el == m_len) begin
            m_el  = 0;
            m_len = (hp == 0) ? 1 : int'(hp);
            m_clk = 1 - m_clk;
            if (m_clk == 1) begin
               m_rise = 1;
               m_cnt  = (m_cnt + 1) % (1 << CW);
            end else begin
               m_fall = 1;
            end
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".clock"}, 32'(clock), 32'(m_clk));
      chk({tag, ".rise"},  32'(clock_rise), 32'(m_rise));
      chk({tag, ".fall"},  32'(clock_fall), 32'(m_fall));
`ifdef CLOCK_GENERATOR_CYCLE_COUNT_EN
      chk({tag, ".count"}, 32'(cycle_count), 32'(m_cnt));
`else
      chk({tag, ".count"}, 32'(cycle_count), 32'd0);
`endif
   endtask

   task automatic step(input string tag);
      en = cur_en; half_period = cur_hp;
      @(posedge clk);
      model_edge(cur_en, cur_hp);
      #1;
      check_outputs(tag);
   endtask

   // Step until the chosen pulse appears and return the number of edges taken.
   // A bound that expires is recorded as a failed check.
   task automatic run_until(input bit want_fall, input string tag, output int n);
      n = 0;
      for (int i = 0; i < 64; i++) begin
         step(tag);
         n++;
         if (want_fall ? clock_fall : clock_rise) return;
      end
      chk({tag, ".timeout"}, 32'd0, 32'd1);
      n = -1;
   endtask

   int n;
   logic [CW-1:0] cnt0;

   initial begin
      rst_n = 1'b0; en = 1'b1; half_period = 8'd5;
      cur_en = 1'b1; cur_hp = 8'd5;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_outputs("reset");

      // Release reset between edges; the first rise is due on the 5th edge.
      #3 rst_n = 1'b1;
      run_until(0, "first_rise", n);
      chk("first_rise_edge", 32'(n), 32'd5);
      run_until(0, "period5", n);
      chk("period5", 32'(n), 32'd10);
      run_until(0, "period5b", n);
      chk("period5b", 32'(n), 32'd10);

      // Drop en two edges into a high phase: 3 more high edges, then the clock holds low.
      step("hi1"); step("hi2");
      cur_en = 1'b0;
      run_until(1, "stop_fall", n);
      chk("stop_fall_edges", 32'(n), 32'd3);
      for (int i = 0; i < 6; i++) step("stopped");
      chk("stopped_low", 32'(clock), 32'd0);
      cur_en = 1'b1;
      run_until(0, "restart", n);
      chk("restart_edges", 32'(n), 32'd5);

      // A mid-phase change from 5 to 3: the current phase still runs 5, and the next runs 3.
      step("mid1"); step("mid2");
      cur_hp = 8'd3;
      run_until(1, "chg_fall", n);
      chk("chg_cur_phase", 32'(n), 32'd3);
      run_until(0, "chg_rise", n);
      chk("chg_next_phase", 32'(n), 32'd3);

      // A half-period of 0 behaves like 1, giving a period of 2.
      cur_hp = 8'd0;
      run_until(0, "hp0_settle", n);
      run_until(0, "hp0", n);
      chk("hp0_period", 32'(n), 32'd2);
      cur_hp = 8'd1;
      run_until(0, "hp1_settle", n);
      run_until(0, "hp1", n);
      chk("hp1_period", 32'(n), 32'd2);

      // Sixteen rises bring the 4-bit counter back to its starting value.
      cnt0 = cycle_count;
      for (int i = 0; i < 16; i++) run_until(0, "wrap", n);
      chk("wrap16", 32'(cycle_count), 32'(cnt0));

      // Assert reset mid high-phase: the outputs clear before the next edge.
      cur_hp = 8'd5;
      run_until(0, "pre_rst", n);
      run_until(0, "pre_rst2", n);
      step("rst_hi1"); step("rst_hi2");
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("async_reset");
      @(posedge clk);
      #3 rst_n = 1'b1;
      run_until(0, "rst_restart", n);
      chk("rst_restart_edges", 32'(n), 32'd5);

      // Randomized en/half_period traffic against the model.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) cur_hp = 8'($urandom_range(0, 6));
         if ($urandom_range(0, 7) == 0) cur_en = ~cur_en;
         step("random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
